// File: rtl/vga_sync_gen_pkg.sv
// Purpose: shared VGA timing defaults, derived totals and the 2-bit phase encoding used by both axes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_sync_gen_pkg;

    // Counter width covers both axes (max 799 / 524).
    localparam int CNT_W = 10;

    // 640x480 @ 60 Hz timing, pixel units horizontally and line units vertically.
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Phase of one axis; identical encoding for horizontal and vertical.
    typedef enum logic [1:0] {
        PH_VIS = 2'd0,
        PH_FP  = 2'd1,
        PH_SY  = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// Purpose: one timing axis - position counter, 4-phase FSM (visible/front/sync/back) and sync decode.
// Latency: count and sync_n are registered and change on the same edge as the advance.
// Backpressure: none; state advances only on cycles with adv=1, otherwise holds.
// Ports: clk, reset (async, active-high), adv (advance one step), count (registered position),
//        at_last (count is on its final value), sync_n (registered active-low sync),
//        vis_nxt (visible flag of the next-state phase, for registering downstream).
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             at_last,
    output logic             sync_n,
    output logic             vis_nxt
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    // Last count of each phase; the phase changes on the advance that leaves it.
    localparam logic [CNT_W-1:0] VIS_LAST = CNT_W'(VISIBLE - 1);
    localparam logic [CNT_W-1:0] FP_LAST  = CNT_W'(VISIBLE + FRONT - 1);
    localparam logic [CNT_W-1:0] SY_LAST  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;
    logic             sync_n_q, sync_n_d;

    assign at_last = (count_q == TOT_LAST);

    always_comb begin
        count_d  = count_q;
        phase_d  = phase_q;
        if (adv) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
            unique case (phase_q)
                PH_VIS: if (count_q == VIS_LAST) phase_d = PH_FP;
                PH_FP:  if (count_q == FP_LAST)  phase_d = PH_SY;
                PH_SY:  if (count_q == SY_LAST)  phase_d = PH_BP;
                PH_BP:  if (at_last)             phase_d = PH_VIS;
                default:                         phase_d = PH_BP;
            endcase
        end
        // Decoding from the next phase keeps sync aligned with the new count.
        sync_n_d = (phase_d != PH_SY);
        vis_nxt  = (phase_d == PH_VIS);
    end

    // Reset parks the axis on its last position so the first advance lands on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= TOT_LAST;
            phase_q  <= PH_BP;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            phase_q  <= phase_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count  = count_q;
    assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: VGA sync generator - pixel/line counters, active-low hsync/vsync, video_on, line/frame pulses.
// Latency: all outputs registered on the same edge as the counters (zero latency relative to pixel_x/y).
// Backpressure: none; pixel_en=0 freezes all state and forces the one-clk pulses low.
// Ports: clk, reset (async, active-high), pixel_en (pixel-rate enable), hsync, vsync, video_on,
//        pixel_x, pixel_y, line_start, frame_start.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    logic h_last, v_last, h_vis_nxt, v_vis_nxt, v_adv;
    logic video_on_q, video_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Vertical axis steps only on the pixel edge where the line wraps.
    assign v_adv = pixel_en & h_last;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (pixel_en),
        .count   (pixel_x),
        .at_last (h_last),
        .sync_n  (hsync),
        .vis_nxt (h_vis_nxt)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (v_adv),
        .count   (pixel_y),
        .at_last (v_last),
        .sync_n  (vsync),
        .vis_nxt (v_vis_nxt)
    );

    always_comb begin
        video_on_d    = h_vis_nxt & v_vis_nxt;
        line_start_d  = v_adv;
        frame_start_d = v_adv & v_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: directed self-checking bench for vga_sync_gen (default timing plus a scaled-down instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic       clk;
    logic       reset, pixel_en;
    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;

    // Scaled-down instance so whole frames fit a short run:
    // H: 8 vis, 2 fp, 3 sync (10..12), 3 bp -> 16; V: 6 vis, 2 fp, 2 sync (8..9), 3 bp -> 13.
    logic       reset_s, pixel_en_s;
    logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
    logic [9:0] pixel_x_s, pixel_y_s;

    int checks = 0;
    int errors = 0;

    vga_sync_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) u_small (
        .clk         (clk),
        .reset       (reset_s),
        .pixel_en    (pixel_en_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .video_on    (video_on_s),
        .pixel_x     (pixel_x_s),
        .pixel_y     (pixel_y_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {hsync, vsync, video_on, line_start, frame_start}.
    task automatic check_reset_main(input string tag);
        check({tag, "_x"}, pixel_x, 799);
        check({tag, "_y"}, pixel_y, 524);
        check({tag, "_flags"}, {hsync, vsync, video_on, line_start, frame_start}, 5'b11000);
    endtask

    initial begin
        int ex, ey, hs_lows, hs_first, vo_first, fs_cnt;
        logic exp_hs, exp_vs, exp_vo, exp_ls, exp_fs;

        reset = 1'b0; pixel_en = 1'b0;
        reset_s = 1'b1; pixel_en_s = 1'b0;

        // Asynchronous reset before any clock edge.
        #3 reset = 1'b1;
        #1 check_reset_main("rst_async");
        step(); step();
        reset = 1'b0;
        step(); step();
        check_reset_main("rst_hold_no_en");

        // First enable lands on (0,0) with both pulses.
        pixel_en = 1'b1; step(); pixel_en = 1'b0;
        check("first_x", pixel_x, 0);
        check("first_y", pixel_y, 0);
        check("first_flags", {hsync, vsync, video_on, line_start, frame_start}, 5'b11111);
        step();
        check("first_pulse_width", {line_start, frame_start}, 2'b00);
        check("first_hold_x", pixel_x, 0);
        step(); step();

        // One full line with pixel_en every 4th clk.
        hs_lows = 0; hs_first = -1; vo_first = -1;
        for (int i = 1; i <= 800; i++) begin
            pixel_en = 1'b1; step(); pixel_en = 1'b0;
            ex = i % 800;
            ey = i / 800;
            exp_hs = !(ex >= 656 && ex <= 751);
            exp_vo = (ex < 640);
            exp_ls = (ex == 0);
            check("line_x", pixel_x, ex);
            check("line_y", pixel_y, ey);
            check("line_flags", {hsync, vsync, video_on, line_start, frame_start},
                  {exp_hs, 1'b1, exp_vo, exp_ls, 1'b0});
            if (hsync === 1'b0) begin
                hs_lows++;
                if (hs_first < 0) hs_first = ex;
            end
            if (video_on === 1'b0 && vo_first < 0) vo_first = ex;
            step();
            check("line_idle_pulses", {line_start, frame_start}, 2'b00);
            step(); step();
        end
        check("hsync_low_count", hs_lows, 96);
        check("hsync_first_x", hs_first, 656);
        check("video_off_first_x", vo_first, 640);

        // Move to x=300 on line 1, then stall 50 clks.
        pixel_en = 1'b1;
        repeat (300) step();
        pixel_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("stall_x", pixel_x, 300);
            check("stall_y", pixel_y, 1);
            check("stall_flags", {hsync, vsync, video_on, line_start, frame_start}, 5'b11100);
            step();
        end

        // Reset asynchronously mid-line at x=700, between clock edges.
        pixel_en = 1'b1;
        repeat (400) step();
        pixel_en = 1'b0;
        check("pre_reset_x", pixel_x, 700);
        check("pre_reset_hs", hsync, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_main("rst_midline");
        step();
        reset = 1'b0;
        pixel_en = 1'b1; step(); pixel_en = 1'b0;
        check("rerun_xy", {pixel_x, pixel_y}, 20'h0);
        check("rerun_flags", {hsync, vsync, video_on, line_start, frame_start}, 5'b11111);

        // Scaled instance, pixel_en tied high: two full frames plus the wrap into a third.
        check("small_rst_xy", {pixel_x_s, pixel_y_s}, {10'd15, 10'd12});
        check("small_rst_flags", {hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s}, 5'b11000);
        reset_s = 1'b0; pixel_en_s = 1'b1;
        fs_cnt = 0;
        for (int n = 0; n <= 416; n++) begin
            step();
            ex = n % 16;
            ey = (n / 16) % 13;
            exp_hs = !(ex >= 10 && ex <= 12);
            exp_vs = !(ey >= 8 && ey <= 9);
            exp_vo = (ex < 8) && (ey < 6);
            exp_ls = (ex == 0);
            exp_fs = (ex == 0) && (ey == 0);
            check("small_x", pixel_x_s, ex);
            check("small_y", pixel_y_s, ey);
            check("small_flags", {hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s},
                  {exp_hs, exp_vs, exp_vo, exp_ls, exp_fs});
            if (frame_start_s === 1'b1) fs_cnt++;
            if (n == 415) check("small_last_xy", {pixel_x_s, pixel_y_s}, {10'd15, 10'd12});
        end
        check("small_frame_count", fs_cnt, 3);

        // Reach (11,8): inside both sync pulses, then reset asynchronously.
        repeat (139) step();
        check("small_sync_xy", {pixel_x_s, pixel_y_s}, {10'd11, 10'd8});
        check("small_sync_flags", {hsync_s, vsync_s, video_on_s}, 3'b000);
        @(posedge clk);
        #3 reset_s = 1'b1;
        #1;
        check("small_rst_mid_xy", {pixel_x_s, pixel_y_s}, {10'd15, 10'd12});
        check("small_rst_mid_flags", {hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s}, 5'b11000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
